// File: rtl/univ_shift_burst.sv
// Universal 4-mode shift register with an autonomous N-position burst shift/rotate sequencer.
// Optional macro UNIV_SHIFT_ARITH_EN adds an arith input that enables sign-extending right bursts.
module univ_shift_burst #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             s0,
  input  logic             s1,
  input  logic             sr,
  input  logic             sl,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic             dir,
  input  logic             rot,
  input  logic [CNT_W-1:0] count,
`ifdef UNIV_SHIFT_ARITH_EN
  input  logic             arith,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             rot_q, rot_d;
  logic             arith_q, arith_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fill;

  // Fill bit for a burst step: rotated-out bit, sign bit, or live serial input.
  always_comb begin
    if (rot_q) begin
      fill = dir_q ? sh_q[WIDTH-1] : sh_q[0];
    end else if (!dir_q && arith_q) begin
      fill = sh_q[WIDTH-1];
    end else begin
      fill = dir_q ? sl : sr;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    arith_d = arith_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_d = RUN;
            rem_d   = count;
            dir_d   = dir;
            rot_d   = rot;
`ifdef UNIV_SHIFT_ARITH_EN
            arith_d = arith;
`else
            arith_d = 1'b0;
`endif
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          case ({s1, s0})
            2'b01:   sh_d = {sr, sh_q[WIDTH-1:1]};
            2'b10:   sh_d = {sh_q[WIDTH-2:0], sl};
            2'b11:   sh_d = d;
            default: sh_d = sh_q;
          endcase
        end
      end
      default: begin
        sh_d  = dir_q ? {sh_q[WIDTH-2:0], fill} : {fill, sh_q[WIDTH-1:1]};
        rem_d = rem_q - 1'b1;
        if (rem_q == 1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      sh_q    <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      arith_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      arith_q <= arith_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q      = sh_q;
  assign sout_r = sh_q[0];
  assign sout_l = sh_q[WIDTH-1];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_burst.sv
// Directed, table-driven bench for univ_shift_burst (WIDTH=8, CNT_W=4) plus multi-cycle burst sequences.
module tb_univ_shift_burst;

  logic       clk = 1'b0;
  logic       clr, s0, s1, sr, sl, start, dir, rot;
  logic [7:0] d;
  logic [3:0] count;
`ifdef UNIV_SHIFT_ARITH_EN
  logic       arith;
`endif
  logic [7:0] q;
  logic       sout_r, sout_l, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  univ_shift_burst #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .clr(clr), .s0(s0), .s1(s1), .sr(sr), .sl(sl), .d(d),
    .start(start), .dir(dir), .rot(rot), .count(count),
`ifdef UNIV_SHIFT_ARITH_EN
    .arith(arith),
`endif
    .q(q), .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic [1:0] s;
    logic       sr, sl;
    logic [7:0] d;
    logic       start, dir, rot;
    logic [3:0] cnt;
    logic [7:0] eq;
    logic       eb, ed;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mk(logic c, logic [1:0] s, logic r, logic l, logic [7:0] dd,
                              logic st, logic di, logic ro, logic [3:0] cn,
                              logic [7:0] eq, logic eb, logic ed);
    vec_t v;
    v.clr = c; v.s = s; v.sr = r; v.sl = l; v.d = dd; v.start = st; v.dir = di;
    v.rot = ro; v.cnt = cn; v.eq = eq; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    clr = 1'b0; s1 = 1'b0; s0 = 1'b0; sr = 1'b0; sl = 1'b0; d = 8'h00;
    start = 1'b0; dir = 1'b0; rot = 1'b0; count = 4'd0;
`ifdef UNIV_SHIFT_ARITH_EN
    arith = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input logic [7:0] eq, input logic eb, input logic ed);
    chk({name, ".q"}, {24'd0, q}, {24'd0, eq});
    chk({name, ".busy"}, {31'd0, busy}, {31'd0, eb});
    chk({name, ".done"}, {31'd0, done}, {31'd0, ed});
  endtask

  initial begin
    idle_inputs();

    //               clr  s     sr    sl    d      st    dir   rot   cnt   eq     busy  done
    vt[0]  = mk(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    vt[1]  = mk(1'b0, 2'b11, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0, 8'hFF, 1'b0, 1'b0);
    vt[2]  = mk(1'b1, 2'b11, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0);
    vt[3]  = mk(1'b0, 2'b11, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0);
    vt[4]  = mk(1'b0, 2'b00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0);
    vt[5]  = mk(1'b0, 2'b00, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0);
    vt[6]  = mk(1'b0, 2'b00, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0);
    vt[7]  = mk(1'b0, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'hD2, 1'b0, 1'b0);
    vt[8]  = mk(1'b0, 2'b11, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0);
    vt[9]  = mk(1'b0, 2'b10, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h4A, 1'b0, 1'b0);
    vt[10] = mk(1'b0, 2'b11, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0);
    vt[11] = mk(1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'd3, 8'h81, 1'b1, 1'b0);
    vt[12] = mk(1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 8'h03, 1'b1, 1'b0);
    vt[13] = mk(1'b0, 2'b11, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd9, 8'h06, 1'b1, 1'b0);
    vt[14] = mk(1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h0C, 1'b0, 1'b1);
    vt[15] = mk(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h0C, 1'b0, 1'b0);
    vt[16] = mk(1'b0, 2'b11, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 4'd0, 8'h0C, 1'b0, 1'b1);
    vt[17] = mk(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h0C, 1'b0, 1'b0);

    #2;
    for (int i = 0; i < 18; i++) begin
      clr = vt[i].clr; {s1, s0} = vt[i].s; sr = vt[i].sr; sl = vt[i].sl; d = vt[i].d;
      start = vt[i].start; dir = vt[i].dir; rot = vt[i].rot; count = vt[i].cnt;
      tick();
      chk($sformatf("vec%0d", i), {q, busy, done}, {vt[i].eq, vt[i].eb, vt[i].ed});
      chk($sformatf("vec%0d.sout", i), {30'd0, sout_l, sout_r}, {30'd0, vt[i].eq[7], vt[i].eq[0]});
    end

    // clr pulsed between edges must not clear q.
    idle_inputs();
    #1 clr = 1'b1;
    #2 clr = 1'b0;
    chk_state("clr_between_edges", 8'h0C, 1'b0, 1'b0);
    tick();
    chk_state("clr_between_edges_post", 8'h0C, 1'b0, 1'b0);

    // Rotate right 9 positions on 8 bits wraps to a net rotate by 1.
    {s1, s0} = 2'b11; d = 8'h01; tick();
    idle_inputs(); start = 1'b1; dir = 1'b0; rot = 1'b1; count = 4'd9; tick();
    chk_state("rotr9_accept", 8'h01, 1'b1, 1'b0);
    idle_inputs(); count = 4'd1;
    for (int k = 0; k < 8; k++) tick();
    chk_state("rotr9_step8", 8'h01, 1'b1, 1'b0);
    tick();
    chk_state("rotr9_final", 8'h80, 1'b0, 1'b1);

    // Back-to-back: start accepted while done is high; left shift filling from sl.
    start = 1'b1; dir = 1'b1; rot = 1'b0; count = 4'd1; sl = 1'b1; tick();
    chk_state("b2b_accept", 8'h80, 1'b1, 1'b0);
    start = 1'b0; tick();
    chk_state("b2b_final", 8'h01, 1'b0, 1'b1);

    // clr during the 2nd cycle of a 5-shift burst.
    idle_inputs(); {s1, s0} = 2'b11; d = 8'h3C; tick();
    idle_inputs(); start = 1'b1; count = 4'd5; tick();
    chk_state("clrmid_accept", 8'h3C, 1'b1, 1'b0);
    idle_inputs(); tick();
    chk_state("clrmid_shift1", 8'h1E, 1'b1, 1'b0);
    clr = 1'b1; tick();
    chk_state("clrmid_clr", 8'h00, 1'b0, 1'b0);
    clr = 1'b0; tick();
    chk_state("clrmid_after", 8'h00, 1'b0, 1'b0);

`ifdef UNIV_SHIFT_ARITH_EN
    // Arithmetic right burst sign-extends and ignores sr.
    {s1, s0} = 2'b11; d = 8'h90; tick();
    idle_inputs(); start = 1'b1; dir = 1'b0; rot = 1'b0; arith = 1'b1; count = 4'd2; tick();
    chk_state("arith_accept", 8'h90, 1'b1, 1'b0);
    idle_inputs(); tick();
    chk_state("arith_shift1", 8'hC8, 1'b1, 1'b0);
    tick();
    chk_state("arith_shift2", 8'hE4, 1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_shift_burst.md
Name: univ_shift_burst

Overview:
- Parametrised 4-mode universal shift register: hold, shift right, shift left, parallel load.
- Adds an autonomous burst-shift sequencer: shift or rotate N positions on a start strobe, with busy/done handshake.
- Used for serialisers, bit-field alignment and barrel-style rotates in the datapath.
- Serial outputs allow chaining of multiple instances.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of the burst count input; max burst = 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  synchronous active-high reset
- s0  in  1  manual mode select, LSB
- s1  in  1  manual mode select, MSB
- sr  in  1  serial input for right shifts; enters at q[WIDTH-1]
- sl  in  1  serial input for left shifts; enters at q[0]
- d  in  WIDTH  parallel load data
- start  in  1  burst request; sampled only in IDLE
- dir  in  1  burst direction: 0 = right, 1 = left; captured at start
- rot  in  1  1 = rotate (fill with the bit shifted out), 0 = fill from sr/sl; captured at start
- count  in  CNT_W  burst length in positions; captured at start
- q  out  WIDTH  register contents
- sout_r  out  1  q[0], combinational
- sout_l  out  1  q[WIDTH-1], combinational
- busy  out  1  burst in progress, registered
- done  out  1  one-cycle burst-complete pulse, registered

Behaviour:
- Reset:
  - clr is sampled on the clk rising edge only and overrides every other input.
  - After a reset edge: q = 0, busy = 0, done = 0, FSM in IDLE, captured dir/rot/count cleared.
- Manual modes apply in IDLE with start = 0, keyed on {s1,s0}:
  - 00: hold.
  - 01: shift right, q <= {sr, q[WIDTH-1:1]}.
  - 10: shift left, q <= {q[WIDTH-2:0], sl}.
  - 11: parallel load, q <= d.
- Shifts always use the current q. No input-bus feedthrough.
- FSM states: IDLE, RUN.
- IDLE, start = 1, count != 0:
  - Capture dir, rot and count into rem; enter RUN.
  - q holds on this edge; start takes priority over s1/s0.
  - busy = 1 from the next cycle.
- IDLE, start = 1, count == 0:
  - Stay in IDLE, q holds.
  - done = 1 for exactly the next cycle.
- RUN, each edge:
  - Shift one position in the captured dir.
  - Fill bit: the bit shifted out if rot = 1, otherwise sr (right) or sl (left), sampled live each cycle.
  - rem decrements by 1.
- RUN with rem == 1:
  - Perform the final shift and return to IDLE.
  - busy = 0 and done = 1 in the following cycle.
- Latency: start accepted at edge t; shifts occur at edges t+1 .. t+N.
  - busy is high for cycles t+1 .. t+N.
  - done is high for the single cycle after edge t+N.
- Back-to-back bursts: start may be asserted in the same cycle done is high; it is accepted, since the FSM is in IDLE.
- While busy:
  - start, s1, s0, d, dir, rot and count are ignored.
  - Changes to count do not affect the running burst.
- count > WIDTH is legal.
  - Rotate wraps modulo WIDTH.
  - A non-rotate burst simply flushes in fill bits.
- clr mid-burst: on that edge q = 0, busy = 0, done is not asserted, FSM returns to IDLE.
- done never asserts in the same cycle as clr-driven state.

Optional Feature:
- Macro: UNIV_SHIFT_ARITH_EN.
- When defined:
  - Adds input arith (1 bit, captured at start).
  - In a burst with dir = 0, rot = 0, arith = 1, the fill bit is q[WIDTH-1] (sign-extending arithmetic right shift) and sr is ignored.
  - arith has no effect on left shifts, rotates or manual modes.
- When undefined: the arith port does not exist and right-burst fill is always sr/rotate per rot.

Test Plan (WIDTH = 8, CNT_W = 4):
- Reset: load 0xFF, then clr = 1 for one edge -> q = 0x00, busy = 0, done = 0; clr is ignored between edges (no async clear).
- Load 0xA5 via {s1,s0} = 11, then 00 for 3 cycles -> q = 0xA5 throughout.
- Manual shifts from 0xA5:
  - Right with sr = 1 -> 0xD2.
  - Reload 0xA5, then left with sl = 0 -> 0x4A.
  - sout_r and sout_l track q[0] and q[7].
- Burst rotate left, q = 0x81, start with dir = 1, rot = 1, count = 3 -> q = 0x03, 0x06, 0x0C on successive edges; busy high 3 cycles; done high 1 cycle after; s1s0 = 11 during the burst is ignored.
- start with count = 0 -> q unchanged, busy stays 0, done pulses once.
- Separately, clr during the 2nd cycle of a count = 5 burst -> q = 0, busy = 0, no done.
- With UNIV_SHIFT_ARITH_EN: q = 0x90, dir = 0, rot = 0, arith = 1, count = 2, sr = 0 -> 0xC8 then 0xE4, done after the 2nd shift.
